// File: rtl/exec_decode_unit.sv
// Decode / ALU / next-PC stage for the single-cycle RV32 subset core.
// Everything is computed combinationally from the current inputs and
// captured into output registers on an enabled clock edge, so all outputs
// appear one clock after the inputs that produced them.
module exec_decode_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            branch,
  output logic            mem_read,
  output logic            memto_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic            cmp_func,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            lt,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target,
  output logic            take_branch,
  output logic [XLEN-1:0] next_pc
);

  // Opcodes and ALU operation encodings
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Combinational decode results (next-state of the output registers)
  logic            branch_d, mem_read_d, memto_reg_d, mem_write_d;
  logic            alu_src_d, reg_write_d, cmp_func_d;
  logic [1:0]      alu_op_d;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result_d;
  logic            zero_d, lt_d;
  logic [XLEN-1:0] pc_plus4_d, branch_target_d, next_pc_d;
  logic            take_branch_d;

  // Output registers
  logic            branch_q, mem_read_q, memto_reg_q, mem_write_q;
  logic            alu_src_q, reg_write_q, cmp_func_q;
  logic [1:0]      alu_op_q;
  logic [XLEN-1:0] alu_result_q;
  logic            zero_q, lt_q;
  logic [XLEN-1:0] pc_plus4_q, branch_target_q, next_pc_q;
  logic            take_branch_q;

  // Main decoder: opcode -> datapath controls; unknown opcodes are all-zero
  always_comb begin
    branch_d    = 1'b0;
    mem_read_d  = 1'b0;
    memto_reg_d = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    alu_op_d    = ALU_ADD;
    cmp_func_d  = 1'b0;
    unique case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        // Only funct7 distinguishes SUB; funct3 is not decoded for R-type
        alu_op_d    = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      end
      OP_ADDI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_LW: begin
        mem_read_d  = 1'b1;
        memto_reg_d = 1'b1;
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_BRANCH: begin
        branch_d   = 1'b1;
        alu_op_d   = ALU_SUB;
        // blt compares with lt; every other funct3 is treated as beq
        cmp_func_d = (funct3 == 3'b100);
      end
      default: ;
    endcase
  end

  // ALU: operand select, operation, zero flag and signed compare
  always_comb begin
    op_b = alu_src_d ? imm : rs2_data;
    unique case (alu_op_d)
      ALU_ADD: alu_result_d = rs1_data + op_b;
      ALU_SUB: alu_result_d = rs1_data - op_b;
      ALU_AND: alu_result_d = rs1_data & op_b;
      ALU_OR:  alu_result_d = rs1_data | op_b;
      default: alu_result_d = '0;
    endcase
    zero_d = (alu_result_d == '0);
    // Signed compare is independent of the selected ALU operation
    lt_d   = ($signed(rs1_data) < $signed(op_b));
  end

  // Next-PC: imm holds offset>>1, so the top bit is dropped by the shift
  always_comb begin
    pc_plus4_d      = pc + XLEN'(4);
    branch_target_d = pc + {imm[XLEN-2:0], 1'b0};
    take_branch_d   = branch_d & (cmp_func_d ? lt_d : zero_d);
    next_pc_d       = take_branch_d ? branch_target_d : pc_plus4_d;
  end

  // Output registers: async clear, capture only when enabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      memto_reg_q     <= 1'b0;
      mem_write_q     <= 1'b0;
      alu_src_q       <= 1'b0;
      reg_write_q     <= 1'b0;
      alu_op_q        <= 2'b00;
      cmp_func_q      <= 1'b0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      lt_q            <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
      take_branch_q   <= 1'b0;
      next_pc_q       <= '0;
    end else if (en) begin
      branch_q        <= branch_d;
      mem_read_q      <= mem_read_d;
      memto_reg_q     <= memto_reg_d;
      mem_write_q     <= mem_write_d;
      alu_src_q       <= alu_src_d;
      reg_write_q     <= reg_write_d;
      alu_op_q        <= alu_op_d;
      cmp_func_q      <= cmp_func_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      lt_q            <= lt_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
      take_branch_q   <= take_branch_d;
      next_pc_q       <= next_pc_d;
    end
  end

  assign branch        = branch_q;
  assign mem_read      = mem_read_q;
  assign memto_reg     = memto_reg_q;
  assign mem_write     = mem_write_q;
  assign alu_src       = alu_src_q;
  assign reg_write     = reg_write_q;
  assign alu_op        = alu_op_q;
  assign cmp_func      = cmp_func_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign lt            = lt_q;
  assign pc_plus4      = pc_plus4_q;
  assign branch_target = branch_target_q;
  assign take_branch   = take_branch_q;
  assign next_pc       = next_pc_q;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Scoreboard bench for exec_decode_unit: stimulus pushes hand-computed
// expected output vectors; a monitor pops one per issued cycle and compares.
module tb_exec_decode_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic        branch, mem_read, memto_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic        cmp_func, zero, lt, take_branch;
  logic [31:0] alu_result, pc_plus4, branch_target, next_pc;

  exec_decode_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .en(en), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .branch(branch), .mem_read(mem_read), .memto_reg(memto_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .alu_op(alu_op), .cmp_func(cmp_func), .alu_result(alu_result),
    .zero(zero), .lt(lt), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .take_branch(take_branch), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  // ctrl = {branch, mem_read, memto_reg, mem_write, alu_src, reg_write, alu_op[1:0], cmp_func}
  localparam logic [8:0] C_ADDI = 9'b0_0_0_0_1_1_00_0;
  localparam logic [8:0] C_LW   = 9'b0_1_1_0_1_1_00_0;
  localparam logic [8:0] C_SW   = 9'b0_0_0_1_1_0_00_0;
  localparam logic [8:0] C_BEQ  = 9'b1_0_0_0_0_0_01_0;
  localparam logic [8:0] C_BLT  = 9'b1_0_0_0_0_0_01_1;
  localparam logic [8:0] C_ADD  = 9'b0_0_0_0_0_1_00_0;
  localparam logic [8:0] C_SUB  = 9'b0_0_0_0_0_1_01_0;
  localparam logic [8:0] C_NONE = 9'b0;

  typedef logic [139:0] vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic issue    = 1'b0;
  logic done     = 1'b0;

  function automatic vec_t mk(input logic [8:0] c, input logic [31:0] res,
                              input logic z, input logic l, input logic [31:0] p4,
                              input logic [31:0] bt, input logic tk, input logic [31:0] np);
    return {c, res, z, l, p4, bt, tk, np};
  endfunction

  function automatic vec_t act();
    return {branch, mem_read, memto_reg, mem_write, alu_src, reg_write, alu_op,
            cmp_func, alu_result, zero, lt, pc_plus4, branch_target, take_branch, next_pc};
  endfunction

  task automatic check(input string name, input vec_t a, input vec_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Drive one input vector at the falling edge and queue its expected result
  task automatic apply(input string name, input logic e_n, input logic [31:0] i,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input vec_t e);
    exp_t x;
    @(negedge clk);
    en = e_n; instr = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
    x.name = name; x.v = e;
    exp_q.push_back(x);
    issue = 1'b1;
  endtask

  // Monitor: one result per issued cycle, sampled after the capturing edge
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      if (issue) begin
        #2;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_underflow: got output with no expected entry");
        end else begin
          x = exp_q.pop_front();
          check(x.name, act(), x.v);
        end
      end
    end
  end

  initial begin
    vec_t nop_exp;
    #3;
    check("reset_state", act(), '0);
    @(negedge clk);
    rstn = 1'b1;

    apply("addi", 1, 32'h00500093, 32'h100, 32'h0, 32'h55, 32'h5,
          mk(C_ADDI, 32'h5, 0, 1, 32'h104, 32'h10A, 0, 32'h104));
    apply("lw", 1, 32'h00812083, 32'h200, 32'h3000, 32'h0, 32'h8,
          mk(C_LW, 32'h3008, 0, 0, 32'h204, 32'h210, 0, 32'h204));
    apply("sw", 1, 32'h00312423, 32'h204, 32'h3000, 32'h1234, 32'h8,
          mk(C_SW, 32'h3008, 0, 0, 32'h208, 32'h214, 0, 32'h208));
    apply("beq_taken", 1, 32'h00208063, 32'h3010, 32'h7, 32'h7, 32'h4,
          mk(C_BEQ, 32'h0, 1, 0, 32'h3014, 32'h3018, 1, 32'h3018));
    apply("beq_not_taken", 1, 32'h00208063, 32'h3010, 32'h7, 32'h8, 32'h4,
          mk(C_BEQ, 32'hFFFFFFFF, 0, 1, 32'h3014, 32'h3018, 0, 32'h3014));
    apply("blt_taken", 1, 32'h0020C063, 32'h400, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE,
          mk(C_BLT, 32'hFFFFFFFE, 0, 1, 32'h404, 32'h3FC, 1, 32'h3FC));
    apply("blt_not_taken", 1, 32'h0020C063, 32'h400, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE,
          mk(C_BLT, 32'h2, 0, 0, 32'h404, 32'h3FC, 0, 32'h404));
    apply("add_r", 1, 32'h002081B3, 32'h500, 32'd10, 32'd20, 32'h999,
          mk(C_ADD, 32'd30, 0, 1, 32'h504, 32'h1832, 0, 32'h504));
    apply("sub_r", 1, 32'h402081B3, 32'h504, 32'd5, 32'd5, 32'h0,
          mk(C_SUB, 32'h0, 1, 0, 32'h508, 32'h504, 0, 32'h508));
    apply("addi_wrap", 1, 32'h00500093, 32'h600, 32'h7FFFFFFF, 32'h0, 32'h1,
          mk(C_ADDI, 32'h80000000, 0, 0, 32'h604, 32'h602, 0, 32'h604));
    apply("beq_imm31_dropped", 1, 32'h00208063, 32'h1000, 32'h1, 32'h2, 32'h80000003,
          mk(C_BEQ, 32'hFFFFFFFF, 0, 1, 32'h1004, 32'h1006, 0, 32'h1004));
    nop_exp = mk(C_NONE, 32'h6, 0, 0, 32'h0, 32'hFFFFFFFC, 0, 32'h0);
    apply("unknown_op_pc_wrap", 1, 32'h0000007F, 32'hFFFFFFFC, 32'h3, 32'h3, 32'h0, nop_exp);
    apply("hold_en0_a", 0, 32'h00208063, 32'h3010, 32'h7, 32'h7, 32'h4, nop_exp);
    apply("hold_en0_b", 0, 32'h00812083, 32'h200, 32'h3000, 32'h0, 32'h8, nop_exp);

    // Asynchronous reset mid-run, applied away from any clock edge
    @(negedge clk);
    issue = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_reset", act(), '0);
    @(negedge clk);
    rstn = 1'b1;
    apply("after_reset_addi", 1, 32'h00500093, 32'h100, 32'h0, 32'h55, 32'h5,
          mk(C_ADDI, 32'h5, 0, 1, 32'h104, 32'h10A, 0, 32'h104));

    @(negedge clk);
    issue = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run cannot hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
